// File: rtl/red_unpack_pkg.sv
// Shared definitions for the nibble-lane unpacker: state encoding, lane geometry
// and the lane selection helper.
package red_unpack_pkg;

   localparam int LANE_W = 4;
   localparam int LANE_N = 4;
   localparam int WORD_W = LANE_W * LANE_N;
   localparam int IDX_W  = 2;
   localparam int OUT_W  = 16;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANE_N - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   // Pick lane idx out of a packed word; lane 0 sits in the low nibble.
   function automatic logic [LANE_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                  input logic [IDX_W-1:0]  idx);
      lane_sel = word[{idx, 2'b00} +: LANE_W];
   endfunction

endpackage

// File: rtl/red_unpack_nibble_ext.sv
// Widens one 4-bit lane to 16 bits, sign- or zero-extending per SIGNED.
module nibble_ext
   import red_unpack_pkg::*;
#(
   parameter int SIGNED = 1
) (
   input  logic [LANE_W-1:0] nib,
   output logic [OUT_W-1:0]  ext
);

   generate
      if (SIGNED != 0) begin : g_sext
         assign ext = {{(OUT_W - LANE_W){nib[LANE_W-1]}}, nib};
      end else begin : g_zext
         assign ext = {{(OUT_W - LANE_W){1'b0}}, nib};
      end
   endgenerate

endmodule

// File: rtl/red_unpack.sv
// Unpacks a 16-bit word into four extended lanes over a valid/ready stream and
// reports their 16-bit running sum with a one-cycle completion pulse.
module red_unpack
   import red_unpack_pkg::*;
#(
   parameter int SIGNED = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last,
   output logic [OUT_W-1:0]  sum,
   output logic              sum_valid
);

   state_e             state_r;
   state_e             state_nx_s;
   logic [IDX_W-1:0]   idx_r;
   logic [WORD_W-1:0]  word_r;
   logic [OUT_W-1:0]   sum_r;
   logic               sum_valid_r;
   logic [LANE_W-1:0]  nib_s;
   logic [OUT_W-1:0]   lane_s;
   logic               accept_s;
   logic               out_hs_s;
   logic               last_hs_s;

   assign nib_s = lane_sel(word_r, idx_r);

   nibble_ext #(
      .SIGNED (SIGNED)
   ) u_ext (
      .nib (nib_s),
      .ext (lane_s)
   );

   // clear overrides both handshakes in its cycle
   assign accept_s  = (state_r == ST_IDLE) && in_valid && !clear;
   assign out_hs_s  = (state_r == ST_EMIT) && out_ready && !clear;
   assign last_hs_s = out_hs_s && (idx_r == LAST_IDX);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state selection
   always_comb begin
      state_nx_s = state_r;
      if (clear) begin
         state_nx_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  state_nx_s = ST_EMIT;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_EMIT: begin
               if (last_hs_s) begin
                  state_nx_s = ST_IDLE;
               end else begin
                  state_nx_s = ST_EMIT;
               end
            end
            default: state_nx_s = ST_IDLE;
         endcase
      end
   end

   // Stream outputs decoded from the current state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_EMIT: begin
            out_valid = 1'b1;
            out_last  = (idx_r == LAST_IDX);
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   assign out_data  = lane_s;
   assign out_idx   = idx_r;
   assign sum       = sum_r;
   assign sum_valid = sum_valid_r;

   // Word latch, lane index and running sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_r      <= {WORD_W{1'b0}};
         idx_r       <= {IDX_W{1'b0}};
         sum_r       <= {OUT_W{1'b0}};
         sum_valid_r <= 1'b0;
      end else if (clear) begin
         idx_r       <= {IDX_W{1'b0}};
         sum_valid_r <= 1'b0;
      end else begin
         sum_valid_r <= last_hs_s;
         if (accept_s) begin
            word_r <= in_data;
            idx_r  <= {IDX_W{1'b0}};
            sum_r  <= {OUT_W{1'b0}};
         end else if (out_hs_s) begin
            sum_r <= sum_r + lane_s;
            if (idx_r != LAST_IDX) begin
               idx_r <= idx_r + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_red_unpack.sv
// Scoreboard bench: a signed and an unsigned instance share stimulus; a monitor
// pops hand-computed expected lanes and sums whenever an instance presents them.
module tb_red_unpack;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        clear;
   logic        out_ready;

   logic        s_in_ready, s_out_valid, s_out_last, s_sum_valid;
   logic [15:0] s_out_data, s_sum;
   logic [1:0]  s_out_idx;
   logic        u_in_ready, u_out_valid, u_out_last, u_sum_valid;
   logic [15:0] u_out_data, u_sum;
   logic [1:0]  u_out_idx;

   red_unpack #(.SIGNED(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .clear(clear), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_data(s_out_data), .out_idx(s_out_idx),
      .out_last(s_out_last), .sum(s_sum), .sum_valid(s_sum_valid)
   );

   red_unpack #(.SIGNED(0)) dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
      .in_data(in_data), .clear(clear), .out_valid(u_out_valid),
      .out_ready(out_ready), .out_data(u_out_data), .out_idx(u_out_idx),
      .out_last(u_out_last), .sum(u_sum), .sum_valid(u_sum_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [18:0] q_lane_s[$];
   logic [18:0] q_lane_u[$];
   logic [15:0] q_sum_s[$];
   logic [15:0] q_sum_u[$];

   logic [15:0] exp_s[4];
   logic [15:0] exp_u[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: compare every presented lane and completed sum against the queues
   always @(negedge clk) begin
      if (rst_n) begin
         if (s_out_valid && out_ready && !clear) begin
            if (q_lane_s.size() == 0) chk("s_unexpected_lane", {13'd0, s_out_idx, 1'b1}, 32'd0);
            else chk("s_lane", {13'd0, s_out_last, s_out_idx, s_out_data}, {13'd0, q_lane_s.pop_front()});
         end
         if (u_out_valid && out_ready && !clear) begin
            if (q_lane_u.size() == 0) chk("u_unexpected_lane", {13'd0, u_out_idx, 1'b1}, 32'd0);
            else chk("u_lane", {13'd0, u_out_last, u_out_idx, u_out_data}, {13'd0, q_lane_u.pop_front()});
         end
         if (s_sum_valid) begin
            if (q_sum_s.size() == 0) chk("s_unexpected_sum_valid", {16'd0, s_sum}, 32'hFFFF_FFFF);
            else chk("s_sum", {16'd0, s_sum}, {16'd0, q_sum_s.pop_front()});
         end
         if (u_sum_valid) begin
            if (q_sum_u.size() == 0) chk("u_unexpected_sum_valid", {16'd0, u_sum}, 32'hFFFF_FFFF);
            else chk("u_sum", {16'd0, u_sum}, {16'd0, q_sum_u.pop_front()});
         end
      end
   end

   task automatic set_exp(input logic [15:0] s0, s1, s2, s3, u0, u1, u2, u3);
      exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
      exp_u[0] = u0; exp_u[1] = u1; exp_u[2] = u2; exp_u[3] = u3;
   endtask

   // Push nlanes expected lanes (and sums if the word completes), then present the word
   task automatic issue(input logic [15:0] w, input int nlanes,
                        input logic [15:0] sum_s_e, input logic [15:0] sum_u_e);
      for (int i = 0; i < nlanes; i++) begin
         q_lane_s.push_back({(i == 3) ? 1'b1 : 1'b0, 2'(i), exp_s[i]});
         q_lane_u.push_back({(i == 3) ? 1'b1 : 1'b0, 2'(i), exp_u[i]});
      end
      if (nlanes == 4) begin
         q_sum_s.push_back(sum_s_e);
         q_sum_u.push_back(sum_u_e);
      end
      chk("in_ready_before_accept", {31'd0, s_in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("out_valid_latency", {30'd0, u_out_valid, s_out_valid}, 32'd3);
      chk("in_ready_low_in_emit", {31'd0, s_in_ready}, 32'd0);
   endtask

   // Consume nlanes handshakes; toggle applies the 1,0,0 out_ready pattern
   task automatic drain(input int nlanes, input bit toggle);
      int hs;
      int cyc;
      hs  = 0;
      cyc = 0;
      while (hs < nlanes && cyc < 60) begin
         out_ready = toggle ? ((cyc % 3) == 0) : 1'b1;
         if (s_out_valid && !out_ready) begin
            chk("s_stall_data", {16'd0, s_out_data}, {16'd0, exp_s[hs]});
            chk("s_stall_idx", {30'd0, s_out_idx}, hs);
         end
         if (s_out_valid && out_ready) hs++;
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      if (hs < nlanes) chk("drain_timeout", hs, nlanes);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      clear     = 1'b0;
      out_ready = 1'b0;
      #12;
      chk("rst_out_valid", {31'd0, s_out_valid}, 32'd0);
      chk("rst_sum", {16'd0, s_sum}, 32'd0);
      chk("rst_sum_valid", {31'd0, s_sum_valid}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", {30'd0, u_in_ready, s_in_ready}, 32'd3);

      // 0x8F31 straight through
      set_exp(16'h0001, 16'h0003, 16'hFFFF, 16'hFFF8, 16'h0001, 16'h0003, 16'h000F, 16'h0008);
      issue(16'h8F31, 4, 16'hFFFB, 16'h001B);
      drain(4, 1'b0);
      @(posedge clk); #1;

      // 0x7777 then 0x8888 back to back
      set_exp(16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007);
      issue(16'h7777, 4, 16'h001C, 16'h001C);
      drain(4, 1'b0);
      chk("b2b_in_ready", {31'd0, s_in_ready}, 32'd1);
      set_exp(16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF8, 16'h0008, 16'h0008, 16'h0008, 16'h0008);
      issue(16'h8888, 4, 16'hFFE0, 16'h0020);
      drain(4, 1'b0);
      @(posedge clk); #1;

      // 0x8F31 with stalls
      set_exp(16'h0001, 16'h0003, 16'hFFFF, 16'hFFF8, 16'h0001, 16'h0003, 16'h000F, 16'h0008);
      issue(16'h8F31, 4, 16'hFFFB, 16'h001B);
      drain(4, 1'b1);
      @(posedge clk); #1;

      // clear after lane 1 handshake
      issue(16'h8F31, 2, 16'h0000, 16'h0000);
      drain(2, 1'b0);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clear_idle", {30'd0, s_out_valid, s_in_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      set_exp(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
      issue(16'h0001, 4, 16'h0001, 16'h0001);
      drain(4, 1'b0);
      @(posedge clk); #1;

      // reset mid-word
      set_exp(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
      issue(16'h1111, 1, 16'h0000, 16'h0000);
      drain(1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {30'd0, u_out_valid, s_out_valid}, 32'd0);
      chk("midrst_sum", {16'd0, s_sum}, 32'd0);
      chk("midrst_sum_valid", {31'd0, s_sum_valid}, 32'd0);
      chk("midrst_idx", {30'd0, s_out_idx}, 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(16'h1111, 4, 16'h0004, 16'h0004);
      drain(4, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      chk("lane_queue_empty", q_lane_s.size() + q_lane_u.size(), 32'd0);
      chk("sum_queue_empty", q_sum_s.size() + q_sum_u.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
